uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 89 ++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop synchronizer, mid-bit sampling and framing-error detect
// Ports: clock, reset (sync, active-high), pin (async serial in, idle high),
//        data (last good byte), valid / framing_error (one-cycle pulses), busy (not IDLE)
module uart_rx #(
  parameter int clocks_per_bit = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pin,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);
  localparam int CW = $clog2(clocks_per_bit) + 1;
  localparam logic [CW-1:0] HALF = CW'(clocks_per_bit / 2);
  localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic sync1, line;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, data_n;
  logic valid_n, fe_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      line <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      data <= '0;
      valid <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync1 <= pin;
      line <= sync1;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      data <= data_n;
      valid <= valid_n;
      framing_error <= fe_n;
    end
  end
  // The START check at HALF re-samples the start bit near its middle; every
  // later sample is a full bit period on, so data and stop land mid-bit too.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    data_n = data;
    valid_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = line ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = line ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        shift_n[idx] = line;
        idx_n = idx + 1'b1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        data_n = line ? shift : data;
        valid_n = line;
        fe_n = !line;
        state_n = line ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = line ? IDLE : WAIT_HIGH;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (frames, back-to-back, glitch, framing error, mid-frame reset)
module tb_uart_rx;
  localparam int CPB = 4;
  localparam int H = CPB / 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pin = 1'b1;
  logic [7:0] data;
  logic valid, framing_error, busy;
  int cyc = 0;
  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] exp_data = 8'h00;
  typedef struct {
    logic fe;
    logic [7:0] d;
    int at;
  } pulse_t;
  pulse_t sb[$];

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clock(clock), .reset(reset), .pin(pin), .data(data),
    .valid(valid), .framing_error(framing_error), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid || framing_error) begin
      pulse_t e;
      n_checks++;
      if (valid && framing_error) begin
        n_fails++;
        $display("FAIL both_pulses cycle %0d: valid and framing_error high together", cyc);
      end else if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_pulse cycle %0d: valid=%b fe=%b data=%h, none required", cyc, valid, framing_error, data);
      end else begin
        e = sb.pop_front();
        if (framing_error !== e.fe || data !== e.d || cyc !== e.at) begin
          n_fails++;
          $display("FAIL pulse: got fe=%b data=%h at cycle %0d, required fe=%b data=%h at cycle %0d",
                   framing_error, data, cyc, e.fe, e.d, e.at);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    pulse_t e;
    e.fe = !stop;
    e.d = stop ? b : exp_data;
    e.at = cyc + 1 + 3 + H + 9 * CPB;
    sb.push_back(e);
    if (stop) exp_data = b;
    pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      pin = b[i];
      tick(CPB);
    end
    pin = stop;
    tick(CPB);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL %s_timeout: %0d pulses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pin = 1'b1;
    tick(2);
    n_checks++;
    if ({data, valid, framing_error, busy} !== 11'd0) begin
      n_fails++;
      $display("FAIL reset_state: data=%h valid=%b fe=%b busy=%b, required all 0", data, valid, framing_error, busy);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b1);
    drain("basic");
    n_checks++;
    if (data !== 8'hA5) begin
      n_fails++;
      $display("FAIL basic_data: got %h, required a5", data);
    end
    tick(CPB);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("back_to_back");
    n_checks++;
    if (data !== 8'hFF) begin
      n_fails++;
      $display("FAIL b2b_data: got %h, required ff", data);
    end
    tick(CPB);
  endtask

  task automatic test_glitch;
    int hi = 0;
    pin = 1'b0;
    tick(1);
    pin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) hi++;
    end
    n_checks++;
    if (hi < 1 || hi > H + 2) begin
      n_fails++;
      $display("FAIL glitch_busy: busy high %0d cycles, required 1..%0d", hi, H + 2);
    end
    n_checks++;
    if (busy !== 1'b0 || data !== exp_data) begin
      n_fails++;
      $display("FAIL glitch_idle: busy=%b data=%h, required busy=0 data=%h", busy, data, exp_data);
    end
  endtask

  task automatic test_framing;
    int lows = 0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy !== 1'b1) lows++;
    end
    drain("framing");
    n_checks++;
    if (lows != 0) begin
      n_fails++;
      $display("FAIL break_busy: busy low %0d cycles while line held low, required 0", lows);
    end
    n_checks++;
    if (data !== exp_data) begin
      n_fails++;
      $display("FAIL framing_data: got %h, required %h", data, exp_data);
    end
    pin = 1'b1;
    tick(5);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL framing_release: busy=%b, required 0", busy);
    end
    tick(CPB);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b = 8'h5A;
    pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      pin = b[i];
      tick(CPB);
    end
    pin = b[4];
    tick(H + 3);
    reset = 1'b1;
    tick(1);
    exp_data = 8'h00;
    n_checks++;
    if ({data, valid, framing_error, busy} !== 11'd0) begin
      n_fails++;
      $display("FAIL midframe_reset: data=%h valid=%b fe=%b busy=%b, required all 0", data, valid, framing_error, busy);
    end
    reset = 1'b0;
    pin = 1'b1;
    tick(3 * CPB);
    send_frame(8'h5A, 1'b1);
    drain("after_reset");
    n_checks++;
    if (data !== 8'h5A) begin
      n_fails++;
      $display("FAIL after_reset_data: got %h, required 5a", data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
